// File: rtl/key_conditioner.sv
// Pushbutton conditioner: per-key synchronizer, debounce filter, press/release/long-press
// strobes and a press-toggled level, all driven from registers.
module key_conditioner #(
    parameter int N_KEYS            = 4,
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic [N_KEYS-1:0] toggle
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_PRESS_CYCLES);

    function automatic logic [LP_W-1:0] sat_inc(input logic [LP_W-1:0] v);
        return (v == LP_MAX) ? v : v + 1'b1;
    endfunction

    // Synchronizer stage; flops keep raw pin polarity so the reset value 1 means released.
    logic [N_KEYS-1:0] sync_p0;
    logic [N_KEYS-1:0] sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
        end
    end

    // Per-key debounce, strobe and long-press stage
    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic            level;
        logic            pressed_r;
        logic            press_r;
        logic            release_r;
        logic            long_r;
        logic            toggle_r;
        logic [DB_W-1:0] db_cnt;
        logic [LP_W-1:0] hold_cnt;

        assign level = ~sync_p1[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pressed_r <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
                toggle_r  <= 1'b0;
                db_cnt    <= '0;
                hold_cnt  <= '0;
            end else begin
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;

                if (level == pressed_r) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    pressed_r <= level;
                    db_cnt    <= '0;
                    press_r   <= level;
                    release_r <= ~level;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end

                toggle_r <= toggle_r ^ press_r;

                // Saturation at LP_MAX guarantees a single long strobe per press
                if (!pressed_r) begin
                    hold_cnt <= '0;
                end else begin
                    hold_cnt <= sat_inc(hold_cnt);
                    long_r   <= (hold_cnt == LP_LAST);
                end
            end
        end

        assign pressed[i]       = pressed_r;
        assign press_pulse[i]   = press_r;
        assign release_pulse[i] = release_r;
        assign long_pulse[i]    = long_r;
        assign toggle[i]        = toggle_r;
    end

endmodule
